// File: rtl/pipe_stage_bank_pkg.sv
// Shared constants for the FD/DX/MW pipeline latch bank.
// The NOP encoding is the all-zero instruction word.
package pipe_stage_bank_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [DEF_WIDTH-1:0] NOP_INSN = '0;

endpackage

// File: rtl/pipe_stage_bank_stage_field_reg.sv
// One WIDTH-bit pipeline field register.
// Priority on each edge: reset > clear > en > hold.
module stage_field_reg
    import pipe_stage_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (clear) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_bank.sv
// FD, DX and MW pipeline latches; each stage stalls/flushes on its own.
// Flushed stages hold a NOP at PC 0 with zeroed operands.
module pipe_stage_bank
    import pipe_stage_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             fd_en,
    input  logic             fd_flush,
    input  logic [WIDTH-1:0] fd_ir_in,
    input  logic [WIDTH-1:0] fd_pc_in,
    output logic [WIDTH-1:0] fd_ir_out,
    output logic [WIDTH-1:0] fd_pc_out,

    input  logic             dx_en,
    input  logic             dx_flush,
    input  logic [WIDTH-1:0] dx_ir_in,
    input  logic [WIDTH-1:0] dx_pc_in,
    input  logic [WIDTH-1:0] dx_a_in,
    input  logic [WIDTH-1:0] dx_b_in,
    output logic [WIDTH-1:0] dx_ir_out,
    output logic [WIDTH-1:0] dx_pc_out,
    output logic [WIDTH-1:0] dx_a_out,
    output logic [WIDTH-1:0] dx_b_out,

    input  logic             mw_en,
    input  logic [WIDTH-1:0] mw_ir_in,
    input  logic [WIDTH-1:0] mw_pc_in,
    input  logic [WIDTH-1:0] mw_o_in,
    input  logic [WIDTH-1:0] mw_d_in,
    output logic [WIDTH-1:0] mw_ir_out,
    output logic [WIDTH-1:0] mw_pc_out,
    output logic [WIDTH-1:0] mw_o_out,
    output logic [WIDTH-1:0] mw_d_out
);

    localparam logic [WIDTH-1:0] NOP = WIDTH'(NOP_INSN);

    // FD: instruction + next-PC
    stage_field_reg #(.WIDTH(WIDTH), .CLR_VAL(NOP)) uFdIr (
        .clock (clock),
        .reset (reset),
        .clear (fd_flush),
        .en    (fd_en),
        .d     (fd_ir_in),
        .q     (fd_ir_out)
    );

    stage_field_reg #(.WIDTH(WIDTH)) uFdPc (
        .clock (clock),
        .reset (reset),
        .clear (fd_flush),
        .en    (fd_en),
        .d     (fd_pc_in),
        .q     (fd_pc_out)
    );

    // DX: instruction, PC and both register operands
    stage_field_reg #(.WIDTH(WIDTH), .CLR_VAL(NOP)) uDxIr (
        .clock (clock),
        .reset (reset),
        .clear (dx_flush),
        .en    (dx_en),
        .d     (dx_ir_in),
        .q     (dx_ir_out)
    );

    stage_field_reg #(.WIDTH(WIDTH)) uDxPc (
        .clock (clock),
        .reset (reset),
        .clear (dx_flush),
        .en    (dx_en),
        .d     (dx_pc_in),
        .q     (dx_pc_out)
    );

    stage_field_reg #(.WIDTH(WIDTH)) uDxA (
        .clock (clock),
        .reset (reset),
        .clear (dx_flush),
        .en    (dx_en),
        .d     (dx_a_in),
        .q     (dx_a_out)
    );

    stage_field_reg #(.WIDTH(WIDTH)) uDxB (
        .clock (clock),
        .reset (reset),
        .clear (dx_flush),
        .en    (dx_en),
        .d     (dx_b_in),
        .q     (dx_b_out)
    );

    // MW never needs a bubble, so its clear is tied off
    stage_field_reg #(.WIDTH(WIDTH), .CLR_VAL(NOP)) uMwIr (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .en    (mw_en),
        .d     (mw_ir_in),
        .q     (mw_ir_out)
    );

    stage_field_reg #(.WIDTH(WIDTH)) uMwPc (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .en    (mw_en),
        .d     (mw_pc_in),
        .q     (mw_pc_out)
    );

    stage_field_reg #(.WIDTH(WIDTH)) uMwO (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .en    (mw_en),
        .d     (mw_o_in),
        .q     (mw_o_out)
    );

    stage_field_reg #(.WIDTH(WIDTH)) uMwD (
        .clock (clock),
        .reset (reset),
        .clear (1'b0),
        .en    (mw_en),
        .d     (mw_d_in),
        .q     (mw_d_out)
    );

endmodule

// File: tb/tb_pipe_stage_bank.sv
// Directed and randomized checks of pipe_stage_bank against a
// per-stage behavioural model compared on every falling edge.
module tb_pipe_stage_bank;

    logic clock = 1'b0;
    logic reset;
    logic fdEn, fdFlush, dxEn, dxFlush, mwEn;
    logic [31:0] fdIr, fdPc, fdIrQ, fdPcQ;
    logic [31:0] dxIr, dxPc, dxA, dxB;
    logic [31:0] dxIrQ, dxPcQ, dxAQ, dxBQ;
    logic [31:0] mwIr, mwPc, mwO, mwD;
    logic [31:0] mwIrQ, mwPcQ, mwOQ, mwDQ;

    int checks = 0;
    int passes = 0;
    bit modelLive = 1'b0;

    logic [31:0] mFd [2];
    logic [31:0] mDx [4];
    logic [31:0] mMw [4];

    always #5 clock = ~clock;

    pipe_stage_bank #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .fd_en     (fdEn),
        .fd_flush  (fdFlush),
        .fd_ir_in  (fdIr),
        .fd_pc_in  (fdPc),
        .fd_ir_out (fdIrQ),
        .fd_pc_out (fdPcQ),
        .dx_en     (dxEn),
        .dx_flush  (dxFlush),
        .dx_ir_in  (dxIr),
        .dx_pc_in  (dxPc),
        .dx_a_in   (dxA),
        .dx_b_in   (dxB),
        .dx_ir_out (dxIrQ),
        .dx_pc_out (dxPcQ),
        .dx_a_out  (dxAQ),
        .dx_b_out  (dxBQ),
        .mw_en     (mwEn),
        .mw_ir_in  (mwIr),
        .mw_pc_in  (mwPc),
        .mw_o_in   (mwO),
        .mw_d_in   (mwD),
        .mw_ir_out (mwIrQ),
        .mw_pc_out (mwPcQ),
        .mw_o_out  (mwOQ),
        .mw_d_out  (mwDQ)
    );

    // Model: each stage is a small array of words that is zeroed,
    // replaced wholesale, or left alone on every rising edge.
    always @(posedge clock) begin
        logic [31:0] inFd [2];
        logic [31:0] inDx [4];
        logic [31:0] inMw [4];
        inFd = '{fdIr, fdPc};
        inDx = '{dxIr, dxPc, dxA, dxB};
        inMw = '{mwIr, mwPc, mwO, mwD};
        if (reset || fdFlush) mFd <= '{default: 32'h0};
        else if (fdEn) mFd <= inFd;
        if (reset || dxFlush) mDx <= '{default: 32'h0};
        else if (dxEn) mDx <= inDx;
        if (reset) mMw <= '{default: 32'h0};
        else if (mwEn) mMw <= inMw;
    end

    always @(negedge clock) begin
        if (modelLive) begin
            checks++;
            if ({fdIrQ, fdPcQ} === {mFd[0], mFd[1]}) passes++;
            else $display("FAIL model_fd t=%0t got %h %h want %h %h",
                          $time, fdIrQ, fdPcQ, mFd[0], mFd[1]);
            checks++;
            if ({dxIrQ, dxPcQ, dxAQ, dxBQ} ===
                {mDx[0], mDx[1], mDx[2], mDx[3]}) passes++;
            else $display("FAIL model_dx t=%0t got %h %h %h %h want %h %h %h %h",
                          $time, dxIrQ, dxPcQ, dxAQ, dxBQ,
                          mDx[0], mDx[1], mDx[2], mDx[3]);
            checks++;
            if ({mwIrQ, mwPcQ, mwOQ, mwDQ} ===
                {mMw[0], mMw[1], mMw[2], mMw[3]}) passes++;
            else $display("FAIL model_mw t=%0t got %h %h %h %h want %h %h %h %h",
                          $time, mwIrQ, mwPcQ, mwOQ, mwDQ,
                          mMw[0], mMw[1], mMw[2], mMw[3]);
        end
    end

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s got %h want %h", name, got, want);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic allIn(input logic [31:0] v);
        fdIr = v; fdPc = v;
        dxIr = v; dxPc = v; dxA = v; dxB = v;
        mwIr = v; mwPc = v; mwO = v; mwD = v;
    endtask

    initial begin
        // reset wins over en and flush
        allIn(32'hFFFF_FFFF);
        reset = 1; fdEn = 1; fdFlush = 1;
        dxEn = 1; dxFlush = 1; mwEn = 1;
        tick();
        modelLive = 1'b1;
        check("rst_fd_ir", fdIrQ, 32'h0);
        check("rst_fd_pc", fdPcQ, 32'h0);
        check("rst_dx_ir", dxIrQ, 32'h0);
        check("rst_dx_b", dxBQ, 32'h0);
        check("rst_mw_ir", mwIrQ, 32'h0);
        check("rst_mw_d", mwDQ, 32'h0);

        // FD load; no change before the edge
        reset = 0; fdFlush = 0; dxFlush = 0;
        allIn(32'h0);
        fdIr = 32'h28A0_0005; fdPc = 32'h0000_0004;
        #2;
        check("pre_edge_fd_ir", fdIrQ, 32'h0);
        tick();
        check("load_fd_ir", fdIrQ, 32'h28A0_0005);
        check("load_fd_pc", fdPcQ, 32'h0000_0004);

        // FD stall while DX/MW keep loading
        fdEn = 0; fdIr = 32'h1234_5678; fdPc = 32'h1234_5678;
        for (int i = 1; i <= 3; i++) begin
            dxIr = 32'h100 + i; mwO = 32'h200 + i;
            tick();
            check("stall_fd_ir", fdIrQ, 32'h28A0_0005);
            check("stall_fd_pc", fdPcQ, 32'h0000_0004);
            check("stall_dx_ir", dxIrQ, 32'h100 + i);
            check("stall_mw_o", mwOQ, 32'h200 + i);
        end

        // DX flush beats stall
        dxIr = 32'hDEAD_BEEF; dxPc = 32'h40; dxA = 7; dxB = 9;
        tick();
        check("dx_load_ir", dxIrQ, 32'hDEAD_BEEF);
        check("dx_load_a", dxAQ, 32'd7);
        dxEn = 0; dxFlush = 1;
        tick();
        check("flush_dx_ir", dxIrQ, 32'h0);
        check("flush_dx_pc", dxPcQ, 32'h0);
        check("flush_dx_a", dxAQ, 32'h0);
        check("flush_dx_b", dxBQ, 32'h0);
        check("flush_fd_held", fdIrQ, 32'h28A0_0005);
        dxFlush = 0; dxEn = 1;

        // MW pass-through, then hold
        mwIr = 32'h4000_0000; mwPc = 32'h10;
        mwO = 32'h100; mwD = 32'hCAFE_BABE;
        tick();
        check("mw_ir", mwIrQ, 32'h4000_0000);
        check("mw_pc", mwPcQ, 32'h10);
        check("mw_o", mwOQ, 32'h100);
        check("mw_d", mwDQ, 32'hCAFE_BABE);
        mwEn = 0; allIn(32'h5555_AAAA);
        tick();
        check("mw_hold_d", mwDQ, 32'hCAFE_BABE);
        check("mw_hold_ir", mwIrQ, 32'h4000_0000);

        // reset mid-operation, then resume
        fdEn = 1; dxEn = 1; mwEn = 1;
        tick();
        check("pre_rst_mw_o", mwOQ, 32'h5555_AAAA);
        reset = 1; allIn(32'h0BAD_F00D);
        tick();
        check("mid_rst_fd_pc", fdPcQ, 32'h0);
        check("mid_rst_dx_a", dxAQ, 32'h0);
        check("mid_rst_mw_d", mwDQ, 32'h0);
        reset = 0;
        tick();
        check("resume_fd_ir", fdIrQ, 32'h0BAD_F00D);
        check("resume_mw_pc", mwPcQ, 32'h0BAD_F00D);

        // random traffic, checked by the model every cycle
        for (int c = 0; c < 500; c++) begin
            reset = ($urandom_range(31) == 0);
            fdEn = ($urandom_range(3) != 0);
            dxEn = ($urandom_range(3) != 0);
            mwEn = ($urandom_range(3) != 0);
            fdFlush = ($urandom_range(4) == 0);
            dxFlush = ($urandom_range(4) == 0);
            fdIr = $urandom; fdPc = $urandom;
            dxIr = $urandom; dxPc = $urandom;
            dxA = $urandom; dxB = $urandom;
            mwIr = $urandom; mwPc = $urandom;
            mwO = $urandom; mwD = $urandom;
            tick();
        end

        @(negedge clock);
        #1;
        modelLive = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
